// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, fetches one word per req/ack transfer and feeds IF/ID.
// A word that finishes under freeze waits in hold_buf; a branch kills or redirects the fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic        xfer;
  logic        slot_free;
  logic [31:0] pc_next;

  assign imem_req    = (state_q == FETCH);
  // A killed transfer keeps presenting its original address until the memory acks it.
  assign imem_addr   = kill_q ? kill_addr_q : pc_q;
  assign xfer        = imem_req & imem_ack;
  assign slot_free   = !valid_q || !freeze;
  assign pc_next     = pc_q + PC_STEP;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    hold_d      = hold_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    kill_d      = kill_q;
    valid_d     = valid_q;

    if (valid_q && !freeze) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!branch_taken && xfer) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (slot_free) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_next;
            valid_d  = 1'b1;
            pc_d     = pc_next;
          end else begin
            hold_d  = imem_rdata;
            pc_d    = pc_next;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // pc already points one step past the held word, which is exactly its pc_out.
        if (!branch_taken && !freeze) begin
          instr_d  = hold_q;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (branch_taken) begin
      valid_d = 1'b0;
      pc_d    = branch_addr;
      hold_d  = '0;
      if (state_q == HOLD) begin
        state_d = FETCH;
      end
      if (imem_req) begin
        if (!imem_ack && !kill_q) begin
          kill_d      = 1'b1;
          kill_addr_d = pc_q;
        end else if (imem_ack) begin
          kill_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      hold_q      <= '0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      kill_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      hold_q      <= hold_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      kill_q      <= kill_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a wait-state memory model feeds a scoreboard of
// expected (instruction, pc_out) pairs that is drained whenever the stage hands one downstream.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc_out;
  logic        w_valid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  bit   drop_next;
  int   checks;
  int   failures;
  int   waits;
  int   wcnt;
  bit   found;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .valid        (valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .freeze       (1'b0),
    .branch_taken (1'b0),
    .branch_addr  (32'h0),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ack     (w_ack),
    .imem_rdata   (w_rdata),
    .instruction  (w_instr),
    .pc_out       (w_pc_out),
    .valid        (w_valid)
  );

  assign w_ack   = w_req;
  assign w_rdata = word(w_addr);

  // Memory model: acks after `waits` request cycles without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign imem_ack   = imem_req && (wcnt >= waits);
  assign imem_rdata = imem_ack ? word(imem_addr) : 32'hBAD0_BAD0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard: consume first, then branch flush, then record the completing transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (valid && !freeze) begin
          chk1("sb_output_expected", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk32("sb_instruction", instruction, e.instr);
            chk32("sb_pc_out", pc_out, e.pc);
          end
        end
        if (branch_taken) begin
          sb_q.delete();
          if (imem_req && !imem_ack) drop_next = 1'b1;
        end else if (imem_req && imem_ack) begin
          if (drop_next) drop_next = 1'b0;
          else sb_q.push_back('{word(imem_addr), imem_addr + 32'd4});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input int ws);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    drop_next    = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    waits        = ws;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; drop_next = 1'b0;
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; waits = 0;

    // Reset state
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk32("rst_instr", instruction, 32'h0);
    chk32("rst_pc_out", pc_out, 32'h0);
    chk32("rst_addr", imem_addr, 32'h0);

    // Zero-wait streaming, plus the wrapping instance starting at 0xFFFF_FFFC
    do_reset(0);
    @(negedge clk);
    chk1("idle_req", imem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk32("zw_addr", imem_addr, 32'(4 * i));
      chk1("zw_req", imem_req, 1'b1);
      chk1("zw_valid", valid, i > 0);
      if (i > 0) chk32("zw_pc_out", pc_out, 32'(4 * i));
      chk32("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(4 * i));
      if (i == 1) chk32("wrap_pc_out", w_pc_out, 32'h0);
    end

    // Three wait states
    do_reset(3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk32("ws_addr", imem_addr, 32'h0);
      chk1("ws_req", imem_req, 1'b1);
      chk1("ws_ack", imem_ack, 1'b0);
      chk1("ws_valid", valid, 1'b0);
    end
    @(negedge clk);
    chk1("ws_ack_cycle", imem_ack, 1'b1);
    chk1("ws_valid_at_ack", valid, 1'b0);
    @(negedge clk);
    chk1("ws_valid_after", valid, 1'b1);
    chk32("ws_next_addr", imem_addr, 32'h4);
    chk1("ws_next_ack", imem_ack, 1'b0);
    repeat (8) @(negedge clk);

    // Freeze while an ack lands: word parked in HOLD, released intact
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    freeze = 1'b1;
    @(negedge clk);
    chk1("fz_valid", valid, 1'b1);
    chk1("fz_ack", imem_ack, 1'b1);
    chk32("fz_addr", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("fz_hold_req", imem_req, 1'b0);
      chk32("fz_hold_instr", instruction, word(32'h0));
      chk32("fz_hold_pc_out", pc_out, 32'h4);
    end
    @(posedge clk); #1;
    freeze = 1'b0;
    @(negedge clk);
    chk1("fz_release_req", imem_req, 1'b0);
    @(negedge clk);
    chk32("fz_held_instr", instruction, word(32'h4));
    chk32("fz_held_pc_out", pc_out, 32'h8);
    chk1("fz_next_req", imem_req, 1'b1);
    chk32("fz_next_addr", imem_addr, 32'h8);

    // Branch two cycles into a wait-stated fetch of 0x8
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    chk1("br_reach_8", found, 1'b1);
    @(posedge clk); #1;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    @(negedge clk);
    chk1("br_no_ack", imem_ack, 1'b0);
    @(posedge clk); #1;
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("br_flush_valid", valid, 1'b0);
    chk32("br_old_addr", imem_addr, 32'h8);
    found = imem_ack;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      chk1("br_wait_valid", valid, 1'b0);
      chk32("br_wait_addr", imem_addr, 32'h8);
      if (imem_ack) found = 1'b1;
    end
    chk1("br_old_ack_seen", found, 1'b1);
    @(negedge clk);
    chk32("br_new_addr", imem_addr, 32'h100);
    chk1("br_new_valid", valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (valid) found = 1'b1;
    end
    chk1("br_output_seen", found, 1'b1);
    chk32("br_pc_out", pc_out, 32'h104);
    chk32("br_instr", instruction, word(32'h100));

    // Branch with a same-cycle ack while frozen
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    @(negedge clk);
    chk1("bf_ack", imem_ack, 1'b1);
    chk32("bf_addr", imem_addr, 32'h4);
    @(posedge clk); #1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("bf_flush_valid", valid, 1'b0);
    chk32("bf_new_addr", imem_addr, 32'h40);
    @(negedge clk);
    chk1("bf_valid", valid, 1'b1);
    chk32("bf_pc_out", pc_out, 32'h44);
    chk32("bf_instr", instruction, word(32'h40));

    // Asynchronous reset in the middle of a wait
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid) found = 1'b1;
    end
    chk1("ar_valid_seen", found, 1'b1);
    chk1("ar_mid_wait", imem_req && !imem_ack, 1'b1);
    #2;
    rst = 1'b0;
    sb_q.delete();
    drop_next = 1'b0;
    #1;
    chk1("ar_req_drop", imem_req, 1'b0);
    chk1("ar_valid_drop", valid, 1'b0);
    chk32("ar_instr", instruction, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    waits = 0;
    rst   = 1'b1;
    @(negedge clk);
    chk1("ar_idle_req", imem_req, 1'b0);
    @(negedge clk);
    chk1("ar_restart_req", imem_req, 1'b1);
    chk32("ar_restart_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk1("ar_restart_valid", valid, 1'b1);
    chk32("ar_restart_pc_out", pc_out, 32'h4);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage in the ARM-style 5-stage pipeline.
- Owns the PC and fetches one 32-bit word per transfer from an instruction memory with variable latency, using a req/ack handshake.
- Presents the instruction and PC+4 to the IF/ID register.
- Honours hazard freeze from the hazard unit and branch redirects from EXE, and keeps wait-state or killed transfers from corrupting the output.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock; all flops are rising-edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; 1 = the downstream stage does not consume the output this cycle.
- branch_taken  in  1  one-cycle redirect pulse from EXE.
- branch_addr  in  32  redirect target, sampled when branch_taken=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  transfer complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched word.
- instruction  out  32  registered instruction to IF/ID.
- pc_out  out  32  registered fetch address + PC_STEP.
- valid  out  1  instruction/pc_out hold a live instruction.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, kill=0, hold_buf=0, valid=0, instruction=0, pc_out=0, imem_req=0.
- States: IDLE, FETCH, HOLD.
- imem_req=1 only in FETCH. imem_addr=pc.
- IDLE -> FETCH on the first clock after reset release.
- A transfer completes in any cycle with imem_req=1 and imem_ack=1; ack with req=0 is ignored. Zero-wait memory (ack the same cycle as req) gives 1 instruction/cycle.
- Output slot free = !valid | !freeze.
- Output consumed when valid=1 and freeze=0; on consume with no new data, valid <= 0.
- FETCH, ack=1, kill=0, branch_taken=0:
  - Slot free: instruction<=rdata, pc_out<=pc+PC_STEP, valid<=1, pc<=pc+PC_STEP; stay in FETCH.
  - Slot not free: hold_buf<=rdata, pc<=pc+PC_STEP, go to HOLD.
- HOLD: imem_req=0. When freeze=0, load the output from hold_buf, with pc_out = the held word's address + PC_STEP (the current pc), valid<=1, then go to FETCH.
- Freeze never drops a fetched word and never duplicates one.
- Branch (priority over freeze and ack):
  - valid<=0 next cycle (flush).
  - pc<=branch_addr.
  - Any hold_buf content is discarded.
  - In FETCH with req=1 and no ack this cycle: kill<=1, and imem_addr keeps the old address until its ack.
  - In FETCH with ack the same cycle: rdata is discarded, and the next cycle requests branch_addr.
  - In HOLD: go to FETCH requesting branch_addr.
- Kill: the next completing ack is discarded (no output load, pc unchanged), kill<=0, and the following cycle requests the redirected pc. A second branch while kill=1 only updates pc.
- Arithmetic: pc+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0). No alignment checks.
- Async reset mid-transfer aborts immediately: imem_req=0 and state=IDLE. The memory must tolerate an abandoned request.

Test Plan:
- Reset then zero-wait memory (ack=req): imem_addr 0,4,8,12 on consecutive cycles; instruction follows rdata one cycle later; pc_out 4,8,12,16; valid=1 from cycle 2.
- Memory with 3 wait states: imem_addr=0 held stable for 3 cycles with req=1; valid stays 0 until the cycle after ack; exactly one instruction per ack.
- freeze=1 for 4 cycles while valid=1 and an ack arrives: enters HOLD, req=0, output unchanged; on freeze=0 the held word appears with pc_out = its address + 4, and the next req is at that address + 4; no word lost or repeated.
- branch_taken (addr 0x100) two cycles into a 3-wait-state fetch of 0x8: the old ack's data is never presented, valid=0; the next req is imem_addr=0x100; the first valid output has pc_out=0x104.
- branch_taken (addr 0x40) in the same cycle as an ack and with freeze=1: rdata dropped, valid=0 next cycle, next req at 0x40; also RESET_PC=32'hFFFF_FFFC wraps to fetch 0 next.
- rst asserted asynchronously mid-wait: imem_req and valid drop immediately; after release the fetch restarts at RESET_PC.
